// File: rtl/mul8_pkg.sv
// mul8_pkg: shared types and constants for the nibble-serial 8x8 multiplier
package mul8_pkg;
  localparam int NIB_W = 4;
  localparam int OP_W = 8;
  localparam int PROD_W = 16;
  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  typedef logic [1:0] step_t;
  localparam logic [3:0] SH_STEP0 = 4'd0;
  localparam logic [3:0] SH_STEP1 = 4'd4;
  localparam logic [3:0] SH_STEP2 = 4'd4;
  localparam logic [3:0] SH_STEP3 = 4'd8;
  function automatic logic [3:0] shift_amt(step_t s);
    return s == 2'd0 ? SH_STEP0 : s == 2'd1 ? SH_STEP1 : s == 2'd2 ? SH_STEP2 : SH_STEP3;
  endfunction
endpackage

// File: rtl/mult4x4_array.sv
// mult4x4_array: combinational unsigned 4x4->8 array multiplier (a, b in; p = a*b out)
module mult4x4_array
  import mul8_pkg::*;
(
  input  logic [NIB_W-1:0]   a,
  input  logic [NIB_W-1:0]   b,
  output logic [2*NIB_W-1:0] p
);
  logic [3:0][7:0] acc;
  assign acc[0] = {4'b0, a & {4{b[0]}}};
  for (genvar r = 1; r < 4; r++) begin : g_row
    logic [7:0] addend;
    logic [7:0] cy;
    assign addend = 8'({4'b0, a & {4{b[r]}}} << r);
    assign cy[0] = 1'b0;
    for (genvar k = 0; k < 8; k++) begin : g_fa
      assign acc[r][k] = acc[r-1][k] ^ addend[k] ^ cy[k];
      if (k < 7) begin : g_c
        assign cy[k+1] = (acc[r-1][k] & addend[k]) | (cy[k] & (acc[r-1][k] ^ addend[k]));
      end
    end
  end
  assign p = acc[3];
endmodule

// File: rtl/mul8_seq_ctrl.sv
// mul8_seq_ctrl: 8x8->16 unsigned multiply over four cycles on one 4x4 array; in_valid/in_ready accept a,b; out_valid/out_ready deliver product; busy, done_cnt status
module mul8_seq_ctrl
  import mul8_pkg::*;
#(
  parameter int ZERO_SKIP = 0,
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   a,
  input  logic [OP_W-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product,
  output logic              busy,
  output logic [CNT_W-1:0]  done_cnt
);
  state_t state_q, state_d;
  step_t step_q, step_d;
  logic [OP_W-1:0] a_q, a_d, b_q, b_d;
  logic [PROD_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [NIB_W-1:0] ma, mb;
  logic [2*NIB_W-1:0] pp;
  logic in_mul, zero_op;
  assign in_mul = state_q == MUL;
  // step[0] selects the high nibble of a, step[1] the high nibble of b; zero outside MUL keeps the array quiet
  assign ma = in_mul ? (step_q[0] ? a_q[7:4] : a_q[3:0]) : '0;
  assign mb = in_mul ? (step_q[1] ? b_q[7:4] : b_q[3:0]) : '0;
  assign zero_op = (ZERO_SKIP != 0) && (a == '0 || b == '0);
  mult4x4_array u_mult (.a(ma), .b(mb), .p(pp));
  always_comb begin
    state_d = state_q;
    step_d = step_q;
    a_d = a_q;
    b_d = b_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (in_valid) begin
        a_d = a;
        b_d = b;
        acc_d = '0;
        step_d = '0;
        state_d = zero_op ? DONE : MUL;
      end
      MUL: begin
        acc_d = acc_q + (PROD_W'(pp) << shift_amt(step_q));
        step_d = step_q + 2'd1;
        state_d = step_q == 2'd3 ? DONE : MUL;
      end
      DONE: if (out_ready) begin
        state_d = IDLE;
        cnt_d = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      step_q <= '0;
      a_q <= '0;
      b_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      step_q <= step_d;
      a_q <= a_d;
      b_q <= b_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
    end
  end
  assign in_ready = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy = state_q != IDLE;
  assign product = out_valid ? acc_q : '0;
  assign done_cnt = cnt_q;
endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// tb_mul8_seq_ctrl: directed self-checking bench for mul8_seq_ctrl (ZERO_SKIP=0 and ZERO_SKIP=1 instances)
module tb_mul8_seq_ctrl;
  logic clk, rst_n, in_valid, out_ready;
  logic [7:0] a, b;
  logic in_ready, out_valid, busy, z_in_ready, z_out_valid, z_busy;
  logic [15:0] product, z_product;
  logic [7:0] done_cnt, z_done_cnt, exp_cnt;
  int tests, fails;

  mul8_seq_ctrl #(.ZERO_SKIP(0), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready), .product(product), .busy(busy), .done_cnt(done_cnt));
  mul8_seq_ctrl #(.ZERO_SKIP(1), .CNT_W(8)) dut_zs (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(z_in_ready), .a(a), .b(b),
    .out_valid(z_out_valid), .out_ready(out_ready), .product(z_product), .busy(z_busy), .done_cnt(z_done_cnt));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input logic [7:0] x, input logic [7:0] y);
    in_valid = 1'b1;
    a = x;
    b = y;
    step();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    exp_cnt++;
  endtask

  task automatic test_reset();
    tests++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      fails++;
      $display("FAIL reset_flags: got rdy/val/busy=%b want 100", {in_ready, out_valid, busy});
    end
    tests++;
    if (product !== 16'h0 || done_cnt !== 8'h0) begin
      fails++;
      $display("FAIL reset_values: got product=%h cnt=%h want 0000 00", product, done_cnt);
    end
  endtask

  task automatic test_basic();
    int n;
    accept(8'h12, 8'h34);
    tests++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL basic_accept: got in_ready=%b busy=%b want 0 1", in_ready, busy);
    end
    wait_valid(n);
    tests++;
    if (n != 4) begin
      fails++;
      $display("FAIL basic_latency: got %0d want 4", n);
    end
    tests++;
    if (product !== 16'h03A8) begin
      fails++;
      $display("FAIL basic_product: got %h want 03a8", product);
    end
    handshake();
    tests++;
    if (done_cnt !== 8'd1 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL basic_done: got cnt=%h in_ready=%b out_valid=%b want 01 1 0", done_cnt, in_ready, out_valid);
    end
  endtask

  task automatic test_values();
    int n;
    accept(8'hFF, 8'hFF);
    a = 8'h00;
    b = 8'h00;
    wait_valid(n);
    tests++;
    if (product !== 16'hFE01) begin
      fails++;
      $display("FAIL max_product: got %h want fe01", product);
    end
    handshake();
    accept(8'hA5, 8'h0F);
    a = 8'h5A;
    b = 8'hC3;
    wait_valid(n);
    tests++;
    if (product !== 16'h09AB) begin
      fails++;
      $display("FAIL a5x0f_product: got %h want 09ab", product);
    end
    handshake();
    tests++;
    if (done_cnt !== 8'd3) begin
      fails++;
      $display("FAIL values_cnt: got %h want 03", done_cnt);
    end
  endtask

  task automatic test_backpressure();
    int n;
    accept(8'h21, 8'h43);
    wait_valid(n);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      a = 8'(i * 17 + 3);
      b = 8'(i * 5 + 1);
      step();
      tests++;
      if (out_valid !== 1'b1 || product !== 16'h08A3 || in_ready !== 1'b0) begin
        fails++;
        $display("FAIL stall_hold[%0d]: got valid=%b product=%h in_ready=%b want 1 08a3 0", i, out_valid, product, in_ready);
      end
    end
    in_valid = 1'b0;
    handshake();
    tests++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || done_cnt !== exp_cnt) begin
      fails++;
      $display("FAIL stall_release: got in_ready=%b busy=%b cnt=%h want 1 0 %h", in_ready, busy, done_cnt, exp_cnt);
    end
  endtask

  task automatic test_zero();
    int n;
    accept(8'h00, 8'h7B);
    tests++;
    if (z_out_valid !== 1'b1 || z_product !== 16'h0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL zero_skip: got zs_valid=%b zs_product=%h valid=%b want 1 0000 0", z_out_valid, z_product, out_valid);
    end
    wait_valid(n);
    tests++;
    if (n != 4 || product !== 16'h0) begin
      fails++;
      $display("FAIL zero_full: got latency=%0d product=%h want 4 0000", n, product);
    end
    handshake();
    tests++;
    if (z_done_cnt !== exp_cnt || done_cnt !== exp_cnt) begin
      fails++;
      $display("FAIL zero_cnt: got %h/%h want %h", done_cnt, z_done_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    accept(8'h80, 8'h02);
    step();
    step();
    rst_n = 1'b0;
    #1;
    tests++;
    if ({in_ready, out_valid, busy} !== 3'b100 || product !== 16'h0 || done_cnt !== 8'h0) begin
      fails++;
      $display("FAIL mid_reset: got rdy/val/busy=%b product=%h cnt=%h want 100 0000 00", {in_ready, out_valid, busy}, product, done_cnt);
    end
    exp_cnt = 8'h0;
    step();
    rst_n = 1'b1;
    accept(8'h03, 8'h05);
    wait_valid(n);
    tests++;
    if (product !== 16'h000F) begin
      fails++;
      $display("FAIL post_reset_product: got %h want 000f", product);
    end
    handshake();
    tests++;
    if (done_cnt !== 8'd1) begin
      fails++;
      $display("FAIL post_reset_cnt: got %h want 01", done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    logic [7:0] x, y;
    logic [15:0] want;
    for (int i = 0; i < 300; i++) begin
      x = 8'(i * 53 + 7);
      y = 8'(i * 29 + i / 8);
      want = 16'(x) * 16'(y);
      accept(x, y);
      wait_valid(n);
      repeat ($urandom_range(0, 3)) step();
      tests++;
      if (product !== want || z_product !== want) begin
        fails++;
        $display("FAIL sweep_product[%0d] %h*%h: got %h/%h want %h", i, x, y, product, z_product, want);
      end
      handshake();
      tests++;
      if (done_cnt !== exp_cnt) begin
        fails++;
        $display("FAIL sweep_cnt[%0d]: got %h want %h", i, done_cnt, exp_cnt);
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    exp_cnt = 8'h0;
    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = 8'h0;
    b = 8'h0;
    #2;
    test_reset();
    #10;
    rst_n = 1'b1;
    step();
    test_basic();
    test_values();
    test_backpressure();
    test_zero();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
